// File: rtl/stereo_window_gen.sv
// Raster-to-3x3 window generator: buffers the two previous lines and emits one
// packed window, with its centre coordinates, for every interior pixel position.
module stereo_window_gen #(
  parameter int unsigned IMG_WIDTH  = 64,
  parameter int unsigned IMG_HEIGHT = 48,
  parameter int unsigned PIX_W      = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [PIX_W-1:0]              s_pixel,
  input  logic                          s_sof,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [9*PIX_W-1:0]            m_window,
  output logic [$clog2(IMG_WIDTH)-1:0]  m_col,
  output logic [$clog2(IMG_HEIGHT)-1:0] m_row,
  output logic                          m_last
);

  localparam int unsigned COL_W = $clog2(IMG_WIDTH);
  localparam int unsigned ROW_W = $clog2(IMG_HEIGHT);
  localparam int unsigned WIN_W = 9 * PIX_W;
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(IMG_HEIGHT - 1);

  // Position of the next accepted pixel
  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;

  // Line buffers (row-1 and row-2) and the two most recent window columns
  logic [PIX_W-1:0] r_buf1 [IMG_WIDTH];
  logic [PIX_W-1:0] r_buf2 [IMG_WIDTH];
  logic [PIX_W-1:0] r_win_c0 [3];
  logic [PIX_W-1:0] r_win_c1 [3];

  // Output register stage
  logic             r_valid;
  logic [WIN_W-1:0] r_window;
  logic [COL_W-1:0] r_col_out;
  logic [ROW_W-1:0] r_row_out;
  logic             r_last;

  logic             w_accept;
  logic             w_emit;
  logic [COL_W-1:0] w_pos_col;
  logic [ROW_W-1:0] w_pos_row;
  logic [PIX_W-1:0] w_new_col [3];
  logic [WIN_W-1:0] w_win_next;

  assign s_ready   = !r_valid || m_ready;
  assign w_accept  = s_valid && s_ready;
  // SOF forces the accepted pixel to (0,0) regardless of the counters
  assign w_pos_col = s_sof ? '0 : r_col;
  assign w_pos_row = s_sof ? '0 : r_row;
  assign w_emit    = w_accept && (w_pos_row >= ROW_W'(2)) && (w_pos_col >= COL_W'(2));

  // Assemble the window that includes the pixel currently being accepted
  always_comb begin
    w_new_col[0] = r_buf2[w_pos_col];
    w_new_col[1] = r_buf1[w_pos_col];
    w_new_col[2] = s_pixel;
    w_win_next   = '0;
    for (int unsigned r = 0; r < 3; r++) begin
      w_win_next[PIX_W*(3*r + 0) +: PIX_W] = r_win_c0[r];
      w_win_next[PIX_W*(3*r + 1) +: PIX_W] = r_win_c1[r];
      w_win_next[PIX_W*(3*r + 2) +: PIX_W] = w_new_col[r];
    end
  end

  // Data storage is intentionally not reset; row/col gating hides stale data
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_buf2[w_pos_col] <= r_buf1[w_pos_col];
      r_buf1[w_pos_col] <= s_pixel;
      for (int unsigned r = 0; r < 3; r++) begin
        r_win_c0[r] <= r_win_c1[r];
        r_win_c1[r] <= w_new_col[r];
      end
    end
  end

  // Raster counters and output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col     <= '0;
      r_row     <= '0;
      r_valid   <= 1'b0;
      r_window  <= '0;
      r_col_out <= '0;
      r_row_out <= '0;
      r_last    <= 1'b0;
    end else if (w_accept) begin
      if (w_pos_col == COL_MAX) begin
        r_col <= '0;
        r_row <= (w_pos_row == ROW_MAX) ? '0 : w_pos_row + ROW_W'(1);
      end else begin
        r_col <= w_pos_col + COL_W'(1);
        r_row <= w_pos_row;
      end
      r_valid <= w_emit;
      if (w_emit) begin
        r_window  <= w_win_next;
        r_col_out <= w_pos_col - COL_W'(1);
        r_row_out <= w_pos_row - ROW_W'(1);
        r_last    <= (w_pos_col == COL_MAX) && (w_pos_row == ROW_MAX);
      end
    end else if (m_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign m_valid  = r_valid;
  assign m_window = r_window;
  assign m_col    = r_col_out;
  assign m_row    = r_row_out;
  assign m_last   = r_last;

endmodule

// File: tb/tb_stereo_window_gen.sv
// Bench for stereo_window_gen: a 4x4 instance for directed scenarios and an 8x6
// instance for random handshakes, both checked against a frame-image scoreboard.
module tb_stereo_window_gen;

  typedef struct {
    logic [71:0] win;
    int          col;
    int          row;
    logic        last;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  // 4x4 instance
  logic        a_s_valid, a_s_ready, a_s_sof, a_m_valid, a_m_ready, a_m_last;
  logic [7:0]  a_s_pixel;
  logic [71:0] a_m_window;
  logic [1:0]  a_m_col, a_m_row;
  // 8x6 instance
  logic        b_s_valid, b_s_ready, b_s_sof, b_m_valid, b_m_ready, b_m_last;
  logic [7:0]  b_s_pixel;
  logic [71:0] b_m_window;
  logic [2:0]  b_m_col, b_m_row;

  stereo_window_gen #(.IMG_WIDTH(4), .IMG_HEIGHT(4), .PIX_W(8)) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .s_valid(a_s_valid), .s_ready(a_s_ready), .s_pixel(a_s_pixel), .s_sof(a_s_sof),
    .m_valid(a_m_valid), .m_ready(a_m_ready), .m_window(a_m_window),
    .m_col(a_m_col), .m_row(a_m_row), .m_last(a_m_last)
  );

  stereo_window_gen #(.IMG_WIDTH(8), .IMG_HEIGHT(6), .PIX_W(8)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .s_valid(b_s_valid), .s_ready(b_s_ready), .s_pixel(b_s_pixel), .s_sof(b_s_sof),
    .m_valid(b_m_valid), .m_ready(b_m_ready), .m_window(b_m_window),
    .m_col(b_m_col), .m_row(b_m_row), .m_last(b_m_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Scoreboard A: image model of the accepted pixels, compared on every handshake
  exp_t       a_q[$];
  logic [7:0] a_img [0:3][0:3];
  int         a_r, a_c, a_nwin, a_nlast;

  always @(negedge clk) begin : mon_a
    exp_t e;
    if (!rst_n) begin
      a_r = 0; a_c = 0; a_q.delete();
    end else begin
      if (a_m_valid && a_m_ready) begin
        checks++;
        if (a_q.size() == 0) begin
          failures++;
          $display("FAIL a_unexpected_window: got centre (%0d,%0d), expected no window", a_m_row, a_m_col);
        end else begin
          e = a_q.pop_front();
          a_nwin++;
          if (a_m_last) a_nlast++;
          if (a_m_window !== e.win || a_m_col !== 2'(e.col) || a_m_row !== 2'(e.row) || a_m_last !== e.last) begin
            failures++;
            $display("FAIL a_window: got %h c%0d r%0d l%b, expected %h c%0d r%0d l%b",
                     a_m_window, a_m_col, a_m_row, a_m_last, e.win, e.col, e.row, e.last);
          end
        end
      end
      if (a_s_valid && a_s_ready) begin
        if (a_s_sof) begin a_r = 0; a_c = 0; end
        a_img[a_r][a_c] = a_s_pixel;
        if (a_r >= 2 && a_c >= 2) begin
          for (int k = 0; k < 9; k++) e.win[8*k +: 8] = a_img[a_r-2+k/3][a_c-2+k%3];
          e.col = a_c - 1; e.row = a_r - 1; e.last = (a_r == 3 && a_c == 3);
          a_q.push_back(e);
        end
        if (a_c == 3) begin a_c = 0; a_r = (a_r == 3) ? 0 : a_r + 1; end
        else a_c++;
      end
    end
  end

  // Scoreboard B plus hold-rule checks while stalled
  exp_t        b_q[$];
  logic [7:0]  b_img [0:5][0:7];
  int          b_r, b_c, b_nwin;
  logic        b_hold, b_hl;
  logic [71:0] b_hw;
  logic [2:0]  b_hc, b_hr;

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (!rst_n) begin
      b_r = 0; b_c = 0; b_q.delete(); b_hold = 1'b0;
    end else begin
      if (b_hold) begin
        checks++;
        if (b_m_valid !== 1'b1 || b_m_window !== b_hw || b_m_col !== b_hc || b_m_row !== b_hr || b_m_last !== b_hl) begin
          failures++;
          $display("FAIL b_hold_stable: got v%b %h c%0d r%0d, expected v1 %h c%0d r%0d",
                   b_m_valid, b_m_window, b_m_col, b_m_row, b_hw, b_hc, b_hr);
        end
      end
      if (b_m_valid && !b_m_ready) begin
        checks++;
        if (b_s_ready !== 1'b0) begin
          failures++;
          $display("FAIL b_stall_s_ready: got %b, expected 0", b_s_ready);
        end
      end
      b_hold = b_m_valid && !b_m_ready;
      b_hw = b_m_window; b_hc = b_m_col; b_hr = b_m_row; b_hl = b_m_last;
      if (b_m_valid && b_m_ready) begin
        checks++;
        if (b_q.size() == 0) begin
          failures++;
          $display("FAIL b_unexpected_window: got centre (%0d,%0d), expected no window", b_m_row, b_m_col);
        end else begin
          e = b_q.pop_front();
          b_nwin++;
          if (b_m_window !== e.win || b_m_col !== 3'(e.col) || b_m_row !== 3'(e.row) || b_m_last !== e.last) begin
            failures++;
            $display("FAIL b_window: got %h c%0d r%0d l%b, expected %h c%0d r%0d l%b",
                     b_m_window, b_m_col, b_m_row, b_m_last, e.win, e.col, e.row, e.last);
          end
        end
      end
      if (b_s_valid && b_s_ready) begin
        if (b_s_sof) begin b_r = 0; b_c = 0; end
        b_img[b_r][b_c] = b_s_pixel;
        if (b_r >= 2 && b_c >= 2) begin
          for (int k = 0; k < 9; k++) e.win[8*k +: 8] = b_img[b_r-2+k/3][b_c-2+k%3];
          e.col = b_c - 1; e.row = b_r - 1; e.last = (b_r == 5 && b_c == 7);
          b_q.push_back(e);
        end
        if (b_c == 7) begin b_c = 0; b_r = (b_r == 5) ? 0 : b_r + 1; end
        else b_c++;
      end
    end
  end

  function automatic logic [71:0] ramp_win(input int base);
    logic [71:0] w;
    for (int k = 0; k < 9; k++) w[8*k +: 8] = 8'(base + 16*(k/3) + k%3);
    return w;
  endfunction

  task automatic a_send(input logic [7:0] px, input logic sof);
    int n;
    n = 0;
    a_s_valid = 1'b1; a_s_pixel = px; a_s_sof = sof;
    while (a_s_ready !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
    if (n >= 200) begin
      checks++; failures++;
      $display("FAIL a_send_timeout: s_ready=%b, expected 1 within 200 cycles", a_s_ready);
    end
    @(posedge clk); #1;
    a_s_valid = 1'b0; a_s_sof = 1'b0;
  endtask

  task automatic b_send(input logic [7:0] px, input logic sof);
    int n;
    n = 0;
    b_s_valid = 1'b1; b_s_pixel = px; b_s_sof = sof;
    while (b_s_ready !== 1'b1 && n < 1000) begin @(posedge clk); #1; n++; end
    if (n >= 1000) begin
      checks++; failures++;
      $display("FAIL b_send_timeout: s_ready=%b, expected 1 within 1000 cycles", b_s_ready);
    end
    @(posedge clk); #1;
    b_s_valid = 1'b0; b_s_sof = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (a_m_valid !== 1'b0 || a_m_window !== 72'd0 || a_m_col !== 2'd0 || a_m_row !== 2'd0 || a_m_last !== 1'b0 || a_s_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_a: got v%b w%h c%0d r%0d l%b sr%b, expected all zero, s_ready 1",
               a_m_valid, a_m_window, a_m_col, a_m_row, a_m_last, a_s_ready);
    end
    checks++;
    if (b_m_valid !== 1'b0 || b_m_window !== 72'd0 || b_m_col !== 3'd0 || b_m_row !== 3'd0 || b_m_last !== 1'b0 || b_s_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_b: got v%b w%h c%0d r%0d l%b sr%b, expected all zero, s_ready 1",
               b_m_valid, b_m_window, b_m_col, b_m_row, b_m_last, b_s_ready);
    end
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (a_m_valid !== 1'b0 || a_s_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release: got m_valid=%b s_ready=%b, expected 0 and 1", a_m_valid, a_s_ready);
    end
  endtask

  task automatic test_ramp();
    int w0, l0;
    w0 = a_nwin; l0 = a_nlast;
    a_m_ready = 1'b1;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        a_send(8'(16*r + c), r == 0 && c == 0);
        if (r == 2 && c == 1) begin
          checks++;
          if (a_m_valid !== 1'b0) begin
            failures++;
            $display("FAIL ramp_early_window: got m_valid=%b, expected 0", a_m_valid);
          end
        end
        if (r == 2 && c == 2) begin
          checks++;
          if (a_m_valid !== 1'b1 || a_m_window !== ramp_win(0) || a_m_col !== 2'd1 || a_m_row !== 2'd1 || a_m_last !== 1'b0) begin
            failures++;
            $display("FAIL ramp_first_window: got v%b %h c%0d r%0d l%b, expected v1 %h c1 r1 l0",
                     a_m_valid, a_m_window, a_m_col, a_m_row, a_m_last, ramp_win(0));
          end
        end
      end
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (a_nwin - w0 !== 4 || a_nlast - l0 !== 1) begin
      failures++;
      $display("FAIL ramp_count: got %0d windows %0d last, expected 4 and 1", a_nwin - w0, a_nlast - l0);
    end
  endtask

  task automatic test_backpressure();
    int w0;
    w0 = a_nwin;
    a_m_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      a_send(8'(16*(i/4) + i%4), i == 0);
      if (i == 10) begin
        a_m_ready = 1'b0;
        a_s_valid = 1'b1; a_s_pixel = 8'(16*2 + 3); a_s_sof = 1'b0;
        for (int s = 0; s < 5; s++) begin
          @(posedge clk); #1;
          checks++;
          if (a_s_ready !== 1'b0 || a_m_valid !== 1'b1 || a_m_window !== ramp_win(0) || a_m_col !== 2'd1 || a_m_row !== 2'd1) begin
            failures++;
            $display("FAIL backpressure_hold: cycle %0d got sr%b v%b %h c%0d r%0d, expected sr0 v1 %h c1 r1",
                     s, a_s_ready, a_m_valid, a_m_window, a_m_col, a_m_row, ramp_win(0));
          end
        end
        a_m_ready = 1'b1;
      end
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (a_nwin - w0 !== 4 || a_q.size() != 0) begin
      failures++;
      $display("FAIL backpressure_count: got %0d windows %0d pending, expected 4 and 0", a_nwin - w0, a_q.size());
    end
  endtask

  task automatic test_sof_resync();
    int w0;
    a_m_ready = 1'b1;
    for (int i = 0; i < 6; i++) a_send(8'(16*(i/4) + i%4), i == 0);
    w0 = a_nwin;
    for (int i = 0; i < 16; i++) begin
      a_send(8'(50 + 16*(i/4) + i%4), i == 0);
      if (i == 9) begin
        checks++;
        if (a_m_valid !== 1'b0 || a_nwin !== w0) begin
          failures++;
          $display("FAIL sof_early_window: got m_valid=%b windows=%0d, expected 0 and %0d", a_m_valid, a_nwin, w0);
        end
      end
      if (i == 10) begin
        checks++;
        if (a_m_valid !== 1'b1 || a_m_window !== ramp_win(50) || a_m_col !== 2'd1 || a_m_row !== 2'd1) begin
          failures++;
          $display("FAIL sof_first_window: got v%b %h c%0d r%0d, expected v1 %h c1 r1",
                   a_m_valid, a_m_window, a_m_col, a_m_row, ramp_win(50));
        end
      end
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (a_nwin - w0 !== 4) begin
      failures++;
      $display("FAIL sof_count: got %0d windows, expected 4", a_nwin - w0);
    end
  endtask

  task automatic test_reset_midframe();
    int w0, l0;
    a_m_ready = 1'b1;
    for (int i = 0; i < 11; i++) a_send(8'(16*(i/4) + i%4), i == 0);
    a_m_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (a_m_valid !== 1'b0 || a_s_ready !== 1'b1 || a_m_window !== 72'd0) begin
      failures++;
      $display("FAIL reset_async: got m_valid=%b s_ready=%b window=%h, expected 0 1 0", a_m_valid, a_s_ready, a_m_window);
    end
    @(posedge clk);
    #3 rst_n = 1'b1;
    a_m_ready = 1'b1;
    w0 = a_nwin; l0 = a_nlast;
    for (int i = 0; i < 16; i++) begin
      a_send(8'(16*(i/4) + i%4), 1'b0);
      if (i == 10) begin
        checks++;
        if (a_m_valid !== 1'b1 || a_m_window !== ramp_win(0) || a_m_col !== 2'd1 || a_m_row !== 2'd1) begin
          failures++;
          $display("FAIL reset_next_frame: got v%b %h c%0d r%0d, expected v1 %h c1 r1",
                   a_m_valid, a_m_window, a_m_col, a_m_row, ramp_win(0));
        end
      end
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (a_nwin - w0 !== 4 || a_nlast - l0 !== 1) begin
      failures++;
      $display("FAIL reset_frame_count: got %0d windows %0d last, expected 4 and 1", a_nwin - w0, a_nlast - l0);
    end
  endtask

  task automatic test_back_to_back();
    int w0, l0;
    w0 = a_nwin; l0 = a_nlast;
    a_m_ready = 1'b1;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 16; i++) begin
        a_send(8'(100*f + 16*(i/4) + i%4), f == 0 && i == 0);
        if (i == 14 || i == 15) begin
          checks++;
          if (a_m_last !== (i == 15)) begin
            failures++;
            $display("FAIL b2b_last: frame %0d pixel %0d got m_last=%b, expected %b", f, i, a_m_last, i == 15);
          end
        end
        if (f == 1 && i == 10) begin
          checks++;
          if (a_m_valid !== 1'b1 || a_m_window !== ramp_win(100) || a_nwin - w0 !== 4) begin
            failures++;
            $display("FAIL b2b_fifth_window: got v%b %h after %0d, expected v1 %h after 4",
                     a_m_valid, a_m_window, a_nwin - w0, ramp_win(100));
          end
        end
      end
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (a_nwin - w0 !== 8 || a_nlast - l0 !== 2) begin
      failures++;
      $display("FAIL b2b_count: got %0d windows %0d last, expected 8 and 2", a_nwin - w0, a_nlast - l0);
    end
  endtask

  task automatic test_random();
    int vd[3] = '{90, 10, 50};
    int rd[3] = '{10, 90, 50};
    int w0, n;
    logic done;
    for (int p = 0; p < 3; p++) begin
      w0 = b_nwin; done = 1'b0; n = 0;
      fork
        begin
          for (int i = 0; i < 48; i++) begin
            while ($urandom_range(99) >= vd[p]) begin @(posedge clk); #1; end
            b_send(8'($urandom_range(255)), i == 0);
          end
          done = 1'b1;
        end
        begin
          while (!(done && b_q.size() == 0) && n < 20000) begin
            b_m_ready = ($urandom_range(99) < rd[p]);
            @(posedge clk); #1;
            n++;
          end
          b_m_ready = 1'b1;
          if (n >= 20000) begin
            checks++; failures++;
            $display("FAIL random_drain_timeout: %0d windows pending, expected 0", b_q.size());
          end
        end
      join
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (b_nwin - w0 !== 24) begin
        failures++;
        $display("FAIL random_count: phase %0d got %0d windows, expected 24", p, b_nwin - w0);
      end
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    a_nwin = 0; a_nlast = 0; b_nwin = 0;
    a_s_valid = 1'b0; a_s_pixel = 8'd0; a_s_sof = 1'b0; a_m_ready = 1'b1;
    b_s_valid = 1'b0; b_s_pixel = 8'd0; b_s_sof = 1'b0; b_m_ready = 1'b1;
    test_reset();
    test_ramp();
    test_backpressure();
    test_sof_resync();
    test_reset_midframe();
    test_back_to_back();
    test_random();
    checks++;
    if (a_q.size() != 0 || b_q.size() != 0) begin
      failures++;
      $display("FAIL final_drain: got %0d/%0d pending windows, expected 0/0", a_q.size(), b_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
